seq_gen: RTL
============

SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 The block SHALL have parameter PAT_W, default 4, pattern length in bits (2..16).
REQ-002 The block SHALL have parameter PATTERN, default 4'b1101, bit pattern sent MSB first.
REQ-003 The block SHALL have parameter GAP_CYC, default 3, idle cycles after each strobe (1..255).
REQ-004 The block SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port start  input  1  single-cycle request to send one pattern.
REQ-007 The block SHALL have port abort  input  1  synchronous cancel of the pattern in progress.
REQ-008 The block SHALL have port loop_i  input  1  request to resend the pattern back-to-back (see REQ-027).
REQ-009 The block SHALL have port bit_p  output  1  single-cycle strobe marking a valid bit.
REQ-010 The block SHALL have port bit_o  output  1  pattern bit, valid while bit_p=1.
REQ-011 The block SHALL have port busy  output  1  high while a pattern is being sent.
REQ-012 The block SHALL have port done  output  1  single-cycle pulse when a pattern completes.
REQ-013 The block SHALL have port sent_cnt  output  8  number of completed patterns.

Function
REQ-014 The FSM SHALL have the states IDLE, SEND, GAP and DONE; all outputs SHALL be registered.
REQ-015 start=1 in IDLE at edge k SHALL give SEND at edge k+1, with bit_p=1, bit_o=PATTERN[PAT_W-1] and busy=1.
REQ-016 SEND SHALL last one cycle, then GAP SHALL last exactly GAP_CYC cycles with bit_p=0 and bit_o=0.
REQ-017 Bit i SHALL strobe at edge k+1+i*(GAP_CYC+1) with bit_o=PATTERN[PAT_W-1-i].
REQ-018 At the end of the gap after the last bit, the FSM SHALL enter DONE for one cycle with done=1 and busy=0, then return to IDLE.
REQ-019 sent_cnt SHALL increment in the DONE cycle and SHALL wrap from 255 to 0.
REQ-020 start SHALL be ignored while busy=1 or in DONE; no request is queued.
REQ-021 abort=1 in SEND or GAP SHALL return the FSM to IDLE at the next edge with bit_p=0, busy=0 and no done pulse; sent_cnt SHALL be unchanged.
REQ-022 abort and start high together in IDLE: abort SHALL win and no transfer starts.
REQ-023 The bit index and gap counter SHALL be sized by $clog2 of PAT_W and of GAP_CYC+1; no counter SHALL overflow for legal parameters.
REQ-024 Illegal state encodings SHALL recover to IDLE at the next edge with all outputs at reset values.

Reset
REQ-025 With rst_n=0, the block SHALL force state=IDLE, bit_p=0, bit_o=0, busy=0, done=0 and sent_cnt=0, independent of clk.
REQ-026 Reset asserted mid-pattern SHALL discard the pattern; the first strobe after release SHALL require a new start.

Configuration
REQ-027 With macro SEQ_GEN_LOOP_EN defined and loop_i=1 at the end of the last gap, the block SHALL go through DONE, with done=1 and sent_cnt incremented, and then enter SEND for bit 0 at the next edge, keeping busy=0 only in the DONE cycle.
REQ-028 Without SEQ_GEN_LOOP_EN, loop_i SHALL be ignored and only start SHALL begin a transfer.

Structure
REQ-029 State encodings and default PATTERN/GAP_CYC constants SHALL live in the shared package seq_pkg.
REQ-030 The gap counter SHALL be the sub-module seq_gap_timer (load, count, expire pulse); everything else SHALL stay in seq_gen.

Verification
REQ-031 Defaults, start at cycle 10 -> bit_p at cycles 11, 15, 19 and 23 with bit_o 1, 1, 0, 1; done at cycle 27; sent_cnt=1.
REQ-032 start re-pulsed at cycles 13 and 20 during a transfer -> the strobe sequence is identical to REQ-031 and there is exactly one done pulse.
REQ-033 abort at cycle 16 -> busy=0 at cycle 17, no further bit_p, no done, sent_cnt unchanged.
REQ-034 rst_n low at cycle 14, high at cycle 18 -> all outputs 0 immediately and no strobe until the next start.
REQ-035 256 patterns sent -> sent_cnt wraps to 0; PAT_W=8, PATTERN=8'hA5, GAP_CYC=1 -> strobes every 2 cycles with bits 1,0,1,0,0,1,0,1.
REQ-036 SEQ_GEN_LOOP_EN defined, loop_i=1 -> after done at cycle 27, bit 0 strobes at cycle 28; SEQ_GEN_LOOP_EN undefined -> IDLE at cycle 28.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the seq_gen serial pattern sender: FSM encoding,
// default pattern and gap constants, counter width.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  localparam int                     DEF_PAT_W   = 4;
  localparam logic [DEF_PAT_W-1:0]   DEF_PATTERN = 4'b1101;
  localparam int                     DEF_GAP_CYC = 3;
  localparam int                     SENT_CNT_W  = 8;

endpackage

// File: rtl/seq_gap_timer.sv
// Idle-gap timer for seq_gen: load arms it for GAP_CYC cycles of count,
// expire pulses combinationally during the last counted cycle.
module seq_gap_timer
  import seq_pkg::*;
#(
  parameter int GAP_CYC = DEF_GAP_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic expire
);

  localparam int            CW       = $clog2(GAP_CYC + 1);
  // Counting down to zero inclusive gives exactly GAP_CYC counted cycles.
  localparam logic [CW-1:0] LOAD_VAL = CW'(GAP_CYC - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (count && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = count && (cnt_q == '0);

endmodule

// File: rtl/seq_gen.sv
// Serial pattern sender: strobes PATTERN MSB first with GAP_CYC idle cycles
// after each bit. Define SEQ_GEN_LOOP_EN to allow back-to-back resend via loop_i.
module seq_gen
  import seq_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter int               GAP_CYC = DEF_GAP_CYC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  loop_i,
  output logic                  bit_p,
  output logic                  bit_o,
  output logic                  busy,
  output logic                  done,
  output logic [SENT_CNT_W-1:0] sent_cnt
);

  localparam int               IDX_W    = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  seq_state_e            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  loop_q, loop_d;
  logic                  illegal_st;
  logic                  gap_load, gap_count, gap_expire;
  logic                  loop_req;

  logic                  bit_p_q, bit_p_d;
  logic                  bit_o_q, bit_o_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [SENT_CNT_W-1:0] sent_cnt_q, sent_cnt_d;

`ifdef SEQ_GEN_LOOP_EN
  assign loop_req = loop_i;
`else
  logic unused_loop_i;
  assign unused_loop_i = loop_i;
  assign loop_req      = 1'b0;
`endif

  seq_gap_timer #(
    .GAP_CYC (GAP_CYC)
  ) u_gap_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (gap_load),
    .count  (gap_count),
    .expire (gap_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      loop_q     <= 1'b0;
      bit_p_q    <= 1'b0;
      bit_o_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sent_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      loop_q     <= loop_d;
      bit_p_q    <= bit_p_d;
      bit_o_q    <= bit_o_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sent_cnt_q <= sent_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    loop_d     = loop_q;
    illegal_st = 1'b0;
    gap_load   = 1'b0;
    gap_count  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_SEND;
          idx_d   = '0;
        end
      end
      ST_SEND: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_GAP;
          gap_load = 1'b1;
        end
      end
      ST_GAP: begin
        gap_count = 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (gap_expire) begin
          if (idx_q == LAST_IDX) begin
            // Loop request is captured as the last gap ends, acted on after DONE.
            state_d = ST_DONE;
            loop_d  = loop_req;
          end else begin
            state_d = ST_SEND;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = loop_q ? ST_SEND : ST_IDLE;
        idx_d   = '0;
        loop_d  = 1'b0;
      end
      default: begin
        state_d    = ST_IDLE;
        idx_d      = '0;
        loop_d     = 1'b0;
        illegal_st = 1'b1;
      end
    endcase
  end

  // Outputs are decoded from the next state so they align with the state flop.
  always_comb begin
    bit_p_d    = 1'b0;
    bit_o_d    = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    sent_cnt_d = sent_cnt_q;
    case (state_d)
      ST_SEND: begin
        bit_p_d = 1'b1;
        bit_o_d = PATTERN[LAST_IDX - idx_d];
        busy_d  = 1'b1;
      end
      ST_GAP: begin
        busy_d = 1'b1;
      end
      ST_DONE: begin
        done_d     = 1'b1;
        sent_cnt_d = sent_cnt_q + 1'b1;
      end
      default: ;
    endcase
    if (illegal_st) begin
      sent_cnt_d = '0;
    end
  end

  assign bit_p    = bit_p_q;
  assign bit_o    = bit_o_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sent_cnt = sent_cnt_q;

endmodule
